// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults
// for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 128;

  // Successor of a producer index with wrap.
  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: first set request bit at or after
// ptr, searching upward with wrap.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int GID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic             any,
  output logic [GID_W-1:0] idx
);

  int j;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_REQ;
      if (req[j]) begin
        any = 1'b1;
        idx = GID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-atomic round-robin
// sharing of one FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int GID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    i_wren,
  output logic [DATA_W-1:0]       i_wrdata,
  input  logic                    o_full,
  output logic                    gnt_valid,
  output logic [GID_W-1:0]        gnt_id
);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [GID_W-1:0] rr_ptr_q;
  logic [GID_W-1:0] rr_ptr_d;
  logic [GID_W-1:0] gnt_id_d;
  logic             pick_any;
  logic [GID_W-1:0] pick_idx;
  logic             busy;
  logic             wr_ok;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign busy      = (state_q == BUSY);
  assign wr_ok     = busy & req_valid[gnt_id] & ~o_full;
  assign gnt_valid = busy;
  assign i_wren    = wr_ok;

  // Only the granted producer sees ready; full blocks it this cycle.
  always_comb begin
    req_ready         = '0;
    req_ready[gnt_id] = wr_ok;
  end

  // Route the granted slice to the FIFO; zero while idle.
  always_comb begin
    i_wrdata = '0;
    if (busy) begin
      i_wrdata = req_data[int'(gnt_id)*DATA_W +: DATA_W];
    end
  end

  // Grant on any request; release and advance pointer on last beat.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = BUSY;
          gnt_id_d = pick_idx;
        end
      end
      BUSY: begin
        if (wr_ok && req_last[gnt_id]) begin
          state_d  = IDLE;
          rr_ptr_d = GID_W'(wrap_inc(int'(gnt_id), N_REQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_id   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id   <= gnt_id_d;
    end
  end

endmodule
